// File: rtl/autoconfig_master.sv
// Zorro II AutoConfig host: walks the $E80000 config chain, allocates bases from the Z2 RAM
// pool and configures or shuts up each board through a simple bus-cycle request interface.
module autoconfig_master #(
    parameter logic [7:0]  POOL_START = 8'h20,
    parameter logic [7:0]  POOL_END   = 8'hA0,
    parameter int unsigned MAX_BOARDS = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  board_count,
    output logic        bus_req,
    output logic        bus_rw,
    output logic [5:0]  bus_off,
    output logic [3:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [3:0]  bus_rdata,
    output logic        cfg_valid,
    output logic [7:0]  cfg_base,
    output logic [2:0]  cfg_size,
    output logic [15:0] cfg_mfg,
    output logic [7:0]  cfg_prod,
    output logic        cfg_shut
);

    typedef enum logic [2:0] {
        StIdle, StRead, StAlloc, StWriteLo, StWriteHi, StShut, StReport, StFinish
    } state_e;

    state_e          state_q, state_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic [3:0]      count_q, count_d, total_q, total_d;
    logic            req_q, req_d, rw_q, rw_d;
    logic [5:0]      off_q, off_d;
    logic [3:0]      wdata_q, wdata_d;
    logic [15:0]     wait_q, wait_d;
    logic [3:0]      idx_q, idx_d;
    logic [8:0][3:0] nib_q, nib_d;
    logic [7:0]      next_free_q, next_free_d, base_q, base_d;
    logic            shut_q, shut_d, abort_q, abort_d;
    logic            cfg_valid_q, cfg_valid_d, cfg_shut_q, cfg_shut_d;
    logic [7:0]      cfg_base_q, cfg_base_d, cfg_prod_q, cfg_prod_d;
    logic [2:0]      cfg_size_q, cfg_size_d;
    logic [15:0]     cfg_mfg_q, cfg_mfg_d;

    logic       timeout, bus_fail, bus_done;
    logic [2:0] size_code;
    logic [8:0] size_u, align_u, base_u, end_u;
    logic       fits, type_ok;
    logic [3:0] cnt_inc;

    // Read index 0..8 -> word offsets 0..4 then 8..11
    function automatic logic [5:0] rd_off(input logic [3:0] idx);
        return (idx < 4'd5) ? {2'b00, idx} : {2'b00, idx + 4'd3};
    endfunction

    assign timeout  = req_q && (wait_q == 16'(TIMEOUT - 1));
    assign bus_fail = req_q && (bus_err || timeout);
    assign bus_done = req_q && (bus_ack || bus_err || timeout);

    // 9-bit allocation so rounding up past $FF cannot wrap into a false fit
    always_comb begin
        size_code = nib_q[1][2:0];
        size_u    = (size_code == 3'd0) ? 9'd128 : (9'd1 << (size_code - 3'd1));
        align_u   = (size_code == 3'd0) ? 9'd32 : size_u;
        base_u    = ({1'b0, next_free_q} + align_u - 9'd1) & ~(align_u - 9'd1);
        end_u     = base_u + size_u;
        fits      = end_u <= {1'b0, POOL_END};
        type_ok   = nib_q[0][3:2] == 2'b11;
        cnt_inc   = count_q + {3'b000, ~shut_q};
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        count_d     = count_q;
        total_d     = total_q;
        req_d       = req_q;
        rw_d        = rw_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        wait_d      = req_q ? wait_q + 16'd1 : wait_q;
        idx_d       = idx_q;
        nib_d       = nib_q;
        next_free_d = next_free_q;
        base_d      = base_q;
        shut_d      = shut_q;
        abort_d     = abort_q;
        cfg_valid_d = 1'b0;
        cfg_base_d  = cfg_base_q;
        cfg_size_d  = cfg_size_q;
        cfg_mfg_d   = cfg_mfg_q;
        cfg_prod_d  = cfg_prod_q;
        cfg_shut_d  = cfg_shut_q;
        if (bus_done) req_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StRead;
                    busy_d      = 1'b1;
                    count_d     = '0;
                    total_d     = '0;
                    idx_d       = '0;
                    abort_d     = 1'b0;
                    next_free_d = POOL_START;
                end
            end
            StRead: begin
                if (!req_q) begin
                    req_d = 1'b1; rw_d = 1'b1; off_d = rd_off(idx_q); wdata_d = '0; wait_d = '0;
                end else if (bus_fail) begin
                    state_d = StFinish;
                end else if (bus_ack) begin
                    nib_d[idx_q] = bus_rdata;
                    if (idx_q == 4'd8) state_d = StAlloc;
                    else               idx_d   = idx_q + 4'd1;
                end
            end
            StAlloc: begin
                if (type_ok && fits) begin
                    base_d      = base_u[7:0];
                    next_free_d = end_u[7:0];
                    shut_d      = 1'b0;
                    state_d     = StWriteLo;
                end else begin
                    shut_d  = 1'b1;
                    state_d = StShut;
                end
            end
            StWriteLo: begin
                if (!req_q) begin
                    req_d = 1'b1; rw_d = 1'b0; off_d = 6'h25; wdata_d = base_q[3:0]; wait_d = '0;
                end else if (bus_fail) begin
                    abort_d = 1'b1;
                    state_d = StReport;
                end else if (bus_ack) begin
                    state_d = StWriteHi;
                end
            end
            StWriteHi: begin
                if (!req_q) begin
                    req_d = 1'b1; rw_d = 1'b0; off_d = 6'h24; wdata_d = base_q[7:4]; wait_d = '0;
                end else if (bus_done) begin
                    abort_d = bus_fail;
                    state_d = StReport;
                end
            end
            StShut: begin
                if (!req_q) begin
                    req_d = 1'b1; rw_d = 1'b0; off_d = 6'h26; wdata_d = 4'h0; wait_d = '0;
                end else if (bus_done) begin
                    abort_d = bus_fail;
                    state_d = StReport;
                end
            end
            StReport: begin
                cfg_valid_d = 1'b1;
                cfg_base_d  = shut_q ? 8'h00 : base_q;
                cfg_size_d  = nib_q[1][2:0];
                cfg_mfg_d   = ~{nib_q[5], nib_q[6], nib_q[7], nib_q[8]};
                cfg_prod_d  = ~{nib_q[2], nib_q[3]};
                cfg_shut_d  = shut_q;
                count_d     = cnt_inc;
                total_d     = total_q + 4'd1;
                idx_d       = '0;
                // Shut-up boards also count toward 15 so a stuck chain cannot loop forever
                if (abort_q || cnt_inc == 4'(MAX_BOARDS) || total_q == 4'd14) state_d = StFinish;
                else                                                       state_d = StRead;
            end
            StFinish: begin
                state_d     = StIdle;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                next_free_d = POOL_START;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            total_q     <= '0;
            req_q       <= 1'b0;
            rw_q        <= 1'b0;
            off_q       <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            idx_q       <= '0;
            nib_q       <= '0;
            next_free_q <= POOL_START;
            base_q      <= '0;
            shut_q      <= 1'b0;
            abort_q     <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_base_q  <= '0;
            cfg_size_q  <= '0;
            cfg_mfg_q   <= '0;
            cfg_prod_q  <= '0;
            cfg_shut_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
            total_q     <= total_d;
            req_q       <= req_d;
            rw_q        <= rw_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            idx_q       <= idx_d;
            nib_q       <= nib_d;
            next_free_q <= next_free_d;
            base_q      <= base_d;
            shut_q      <= shut_d;
            abort_q     <= abort_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_base_q  <= cfg_base_d;
            cfg_size_q  <= cfg_size_d;
            cfg_mfg_q   <= cfg_mfg_d;
            cfg_prod_q  <= cfg_prod_d;
            cfg_shut_q  <= cfg_shut_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign board_count = count_q;
    assign bus_req     = req_q;
    assign bus_rw      = rw_q;
    assign bus_off     = off_q;
    assign bus_wdata   = wdata_q;
    assign cfg_valid   = cfg_valid_q;
    assign cfg_base    = cfg_base_q;
    assign cfg_size    = cfg_size_q;
    assign cfg_mfg     = cfg_mfg_q;
    assign cfg_prod    = cfg_prod_q;
    assign cfg_shut    = cfg_shut_q;

endmodule

// File: tb/tb_autoconfig_master.sv
// Randomized scoreboard bench for autoconfig_master: a board-chain slave model answers bus
// cycles, a reference walk predicts bus ops, reports and final counts.
module tb_autoconfig_master;

    localparam int unsigned TIMEOUT = 255;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, bus_req, bus_rw, bus_ack, bus_err, cfg_valid, cfg_shut;
    logic [3:0]  board_count, bus_wdata, bus_rdata;
    logic [5:0]  bus_off;
    logic [7:0]  cfg_base, cfg_prod;
    logic [2:0]  cfg_size;
    logic [15:0] cfg_mfg;

    always #5 CLK = ~CLK;

    autoconfig_master #(
        .POOL_START(8'h20), .POOL_END(8'hA0), .MAX_BOARDS(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done),
        .board_count(board_count), .bus_req(bus_req), .bus_rw(bus_rw), .bus_off(bus_off),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
        .cfg_valid(cfg_valid), .cfg_base(cfg_base), .cfg_size(cfg_size), .cfg_mfg(cfg_mfg),
        .cfg_prod(cfg_prod), .cfg_shut(cfg_shut)
    );

    typedef struct packed {
        logic [7:0] base; logic [2:0] size; logic [15:0] mfg; logic [7:0] prod; logic shut;
    } rep_t;
    typedef struct packed {logic rw; logic [5:0] off; logic [3:0] data;} op_t;

    rep_t exp_rep[$];
    op_t  exp_op[$];
    int   exp_cnt[$];
    int   checks = 0;
    int   failures = 0;
    int   rd_offs[9] = '{0, 1, 2, 3, 4, 8, 9, 10, 11};

    // Board chain as seen by the slave
    int         nb = 0;
    bit         b_valid[16];
    logic [2:0] b_code[16];
    logic [15:0] b_mfg[16];
    logic [7:0] b_prod[16];
    logic [3:0] b_nib[16][9];
    int         cur, dly;
    int         slave_mode = 0;
    bit         hold24 = 1'b0;
    bit         chk_bus = 1'b1;
    bit         chk_tmo = 1'b0;
    int         done_cnt = 0;

    // Monitor state
    bit         prev_req = 1'b0;
    bit         unstable = 1'b0;
    int         req_len = 0;
    logic       rw_l;
    logic [5:0] off_l;
    logic [3:0] wd_l;

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic logic [3:0] rd_nib(input int b, input logic [5:0] off);
        if (off < 6'd5) return b_nib[b][int'(off)];
        if (off >= 6'd8 && off <= 6'd11) return b_nib[b][int'(off) - 3];
        return 4'hF;
    endfunction

    task automatic add_board(input bit valid, input logic [3:0] n00, input logic [2:0] code,
                             input logic [15:0] mfg, input logic [7:0] prod);
        b_valid[nb] = valid;
        b_code[nb]  = code;
        b_mfg[nb]   = mfg;
        b_prod[nb]  = prod;
        b_nib[nb][0] = n00;
        b_nib[nb][1] = {1'($urandom_range(0, 1)), code};
        b_nib[nb][2] = ~prod[7:4];
        b_nib[nb][3] = ~prod[3:0];
        b_nib[nb][4] = 4'($urandom_range(0, 15));
        b_nib[nb][5] = ~mfg[15:12];
        b_nib[nb][6] = ~mfg[11:8];
        b_nib[nb][7] = ~mfg[7:4];
        b_nib[nb][8] = ~mfg[3:0];
        nb++;
    endtask

    task automatic add_random_board();
        bit valid;
        logic [3:0] n00;
        logic [2:0] code;
        valid = $urandom_range(0, 7) != 0;
        n00 = valid ? {2'b11, 2'($urandom_range(0, 3))}
                    : {2'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
        code = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(1, 3)) : 3'($urandom_range(0, 7));
        add_board(valid, n00, code, 16'($urandom), 8'($urandom));
    endtask

    // Reference walk: pool allocation by plain integer arithmetic
    task automatic model_walk();
        int nf, cnt, total, sz, al, base;
        bit ended_by_limit;
        rep_t r;
        logic [7:0] b8;
        nf = 'h20; cnt = 0; total = 0; ended_by_limit = 1'b0;
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < 9; k++) exp_op.push_back({1'b1, 6'(rd_offs[k]), 4'h0});
            sz   = (b_code[i] == 0) ? 128 : (1 << (int'(b_code[i]) - 1));
            al   = (b_code[i] == 0) ? 32 : sz;
            base = ((nf + al - 1) / al) * al;
            b8   = 8'(base);
            r.size = b_code[i]; r.mfg = b_mfg[i]; r.prod = b_prod[i];
            if (b_valid[i] && base + sz <= 'hA0) begin
                exp_op.push_back({1'b0, 6'h25, b8[3:0]});
                exp_op.push_back({1'b0, 6'h24, b8[7:4]});
                nf = base + sz; cnt++;
                r.base = b8; r.shut = 1'b0;
            end else begin
                exp_op.push_back({1'b0, 6'h26, 4'h0});
                r.base = 8'h00; r.shut = 1'b1;
            end
            exp_rep.push_back(r);
            total++;
            if (cnt == 8 || total == 15) begin
                ended_by_limit = 1'b1;
                break;
            end
        end
        if (!ended_by_limit) exp_op.push_back({1'b1, 6'h00, 4'h0});
        exp_cnt.push_back(cnt);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic run_walk(input string name, input bit dbl_start);
        int d0;
        d0 = done_cnt;
        pulse_start();
        if (dbl_start) begin
            repeat ($urandom_range(1, 15)) @(negedge CLK);
            if (busy) pulse_start();
        end
        for (int c = 0; c < 20000 && done_cnt == d0; c++) @(negedge CLK);
        check(done_cnt == d0 + 1, {name, "_done"},
              $sformatf("done pulses got %0d want 1", done_cnt - d0));
        repeat (3) @(negedge CLK);
        check(exp_rep.size() == 0 && exp_op.size() == 0 && exp_cnt.size() == 0,
              {name, "_drain"}, $sformatf("left reps=%0d ops=%0d dones=%0d want 0/0/0",
              exp_rep.size(), exp_op.size(), exp_cnt.size()));
        exp_rep.delete(); exp_op.delete(); exp_cnt.delete();
    endtask

    // Chain slave: ack after a random delay, bus_err past the end of the chain
    initial begin
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 4'h0; cur = 0; dly = 0;
        forever begin
            @(negedge CLK);
            if (!busy) cur = 0;
            if (RST || bus_ack || bus_err) begin
                bus_ack = 1'b0;
                bus_err = 1'b0;
            end else if (bus_req) begin
                if (dly > 0) dly--;
                else if (slave_mode == 0 && !(hold24 && !bus_rw && bus_off == 6'h24)) begin
                    dly = $urandom_range(0, 2);
                    if (cur >= nb) bus_err = 1'b1;
                    else begin
                        bus_ack = 1'b1;
                        if (bus_rw) bus_rdata = rd_nib(cur, bus_off);
                        else if (bus_off == 6'h24 || bus_off == 6'h26) cur++;
                    end
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request, report or done
    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_req = 1'b0;
                req_len = 0;
            end else begin
                if (bus_req && !prev_req) begin
                    req_len = 1; unstable = 1'b0;
                    rw_l = bus_rw; off_l = bus_off; wd_l = bus_wdata;
                    if (chk_bus) begin
                        if (exp_op.size() == 0) begin
                            check(1'b0, "bus_op", $sformatf("got rw=%0b off=%h want no request",
                                  bus_rw, bus_off));
                        end else begin
                            op_t e;
                            e = exp_op.pop_front();
                            check(bus_rw == e.rw && bus_off == e.off && (bus_rw || bus_wdata == e.data),
                                  "bus_op", $sformatf("got rw=%0b off=%h wd=%h want rw=%0b off=%h wd=%h",
                                  bus_rw, bus_off, bus_wdata, e.rw, e.off, e.data));
                        end
                    end
                end else if (bus_req) begin
                    req_len++;
                    if (bus_rw != rw_l || bus_off != off_l || bus_wdata != wd_l) unstable = 1'b1;
                end else if (prev_req) begin
                    if (chk_bus) check(!unstable, "bus_hold", "got request fields changing want stable");
                    if (chk_tmo) check(req_len == TIMEOUT, "timeout_len",
                                       $sformatf("got %0d cycles want %0d", req_len, TIMEOUT));
                end
                prev_req = bus_req;

                if (cfg_valid) begin
                    rep_t g;
                    g.base = cfg_base; g.size = cfg_size; g.mfg = cfg_mfg;
                    g.prod = cfg_prod; g.shut = cfg_shut;
                    if (exp_rep.size() == 0) begin
                        check(1'b0, "cfg_report", $sformatf("got base=%h shut=%0b want no report",
                              cfg_base, cfg_shut));
                    end else begin
                        rep_t e;
                        e = exp_rep.pop_front();
                        check(g == e, "cfg_report", $sformatf(
                              "got base=%h size=%0d mfg=%h prod=%h shut=%0b want base=%h size=%0d mfg=%h prod=%h shut=%0b",
                              g.base, g.size, g.mfg, g.prod, g.shut, e.base, e.size, e.mfg, e.prod, e.shut));
                    end
                end

                if (done) begin
                    done_cnt++;
                    if (exp_cnt.size() == 0) begin
                        check(1'b0, "done", "got done pulse want none");
                    end else begin
                        int e;
                        e = exp_cnt.pop_front();
                        check(int'(board_count) == e && !busy && !bus_req, "done_count",
                              $sformatf("got count=%0d busy=%0b req=%0b want count=%0d busy=0 req=0",
                              board_count, busy, bus_req, e));
                    end
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        repeat (3) @(negedge CLK);
        check({busy, done, board_count, bus_req, bus_rw, bus_off, bus_wdata, cfg_valid, cfg_base,
               cfg_size, cfg_mfg, cfg_prod, cfg_shut} == '0, "reset_state",
              $sformatf("got busy=%0b req=%0b count=%0d cfg_valid=%0b want all zero",
              busy, bus_req, board_count, cfg_valid));
        RST = 1'b0;
        @(negedge CLK);

        nb = 0; add_board(1'b1, 4'hE, 3'd6, 16'h4001, 8'hEF);
        model_walk(); run_walk("single", 1'b0);

        nb = 0; add_board(1'b1, 4'hC, 3'd1, 16'h1234, 8'h01);
        add_board(1'b1, 4'hE, 3'd6, 16'h0202, 8'h02);
        model_walk(); run_walk("gap", 1'b0);

        nb = 0; for (int i = 0; i < 5; i++) add_board(1'b1, 4'hE, 3'd6, 16'(i), 8'(i));
        model_walk(); run_walk("five_2m", 1'b0);

        nb = 0; add_board(1'b0, 4'h6, 3'd1, 16'hDEAD, 8'h11);
        add_board(1'b1, 4'hD, 3'd0, 16'hBEEF, 8'h22);
        model_walk(); run_walk("bad_type", 1'b1);

        nb = 0; for (int i = 0; i < 16; i++) add_board(1'b0, 4'h4, 3'd1, 16'(i), 8'(i));
        model_walk(); run_walk("limit15", 1'b0);

        nb = 0; model_walk(); run_walk("empty", 1'b0);

        for (int r = 0; r < 20; r++) begin
            nb = 0;
            for (int i = 0; i < int'($urandom_range(0, 12)); i++) add_random_board();
            model_walk();
            run_walk($sformatf("rand%0d", r), r[0]);
        end

        nb = 0; slave_mode = 1; chk_tmo = 1'b1;
        exp_op.push_back({1'b1, 6'h00, 4'h0});
        exp_cnt.push_back(0);
        run_walk("timeout", 1'b0);
        slave_mode = 0; chk_tmo = 1'b0;

        // Reset while the $48 write is outstanding, then a clean rewalk
        nb = 0; add_board(1'b1, 4'hE, 3'd6, 16'h4001, 8'hEF);
        hold24 = 1'b1; chk_bus = 1'b0;
        pulse_start();
        found = 0;
        for (int c = 0; c < 2000 && found == 0; c++) begin
            @(negedge CLK);
            if (bus_req && !bus_rw && bus_off == 6'h24) found = 1;
        end
        check(found == 1, "hold_48", "got no $48 request want one pending");
        #2 RST = 1'b1;
        #1;
        check({busy, done, board_count, bus_req, bus_rw, bus_off, bus_wdata, cfg_valid, cfg_base,
               cfg_size, cfg_mfg, cfg_prod, cfg_shut} == '0, "async_reset",
              $sformatf("got busy=%0b req=%0b off=%h want all zero", busy, bus_req, bus_off));
        @(negedge CLK);
        RST = 1'b0; hold24 = 1'b0; chk_bus = 1'b1;
        exp_rep.delete(); exp_op.delete(); exp_cnt.delete();
        @(negedge CLK);
        model_walk(); run_walk("rewalk", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
